// File: rtl/wb_deserializer_out.sv
// Serial-link receiver: rebuilds a 27-bit, three-symbol frame and exposes it on a Wishbone slave.
// Optional `WB_DESERIALIZER_IRQ_EN adds a registered irq_o = valid | ovr | frm_err.
//
// state | meaning
// IDLE  | line idle, waiting for a start edge (only state with busy=0)
// START | half-bit wait, confirm start bit is still low
// DATA  | sample 27 payload bits MSB first, one per bit period
// STOP  | sample stop bit, then load the frame or flag a framing error
module wb_deserializer_out #(
    parameter int CLKS_PER_BIT = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int ADDR_SIZE    = 2
) (
    input  logic        CLK_I,
    input  logic        RST_NI,
    input  logic        data_i,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [31:0] ADR_I,
    input  logic [31:0] DAT_I,
    output logic        ACK_O,
    output logic        ERR_O,
    output logic [31:0] DAT_O
`ifdef WB_DESERIALIZER_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_SIZE-1:0] A_DATA   = ADDR_SIZE'(0);
    localparam logic [ADDR_SIZE-1:0] A_STATUS = ADDR_SIZE'(1);
    localparam logic [ADDR_SIZE-1:0] A_CTRL   = ADDR_SIZE'(2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [4:0]             bit_q, bit_d;
    logic [26:0]            sh_q, sh_d;
    logic [26:0]            data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ovr_q, ovr_d;
    logic                   frm_q, frm_d;
    logic                   en_q, en_d;
    logic                   rxs, load, frm_set, busy;
    logic                   req, sel_data, sel_status, sel_ctrl, mapped, legal;
    logic                   rd_data_ack, st_wr, ctrl_wr;
    logic                   unused_ok;

    assign rxs       = sync_q[SYNC_STAGES-1];
    assign busy      = (state_q != IDLE);
    assign unused_ok = ^{ADR_I[31:ADDR_SIZE], DAT_I[31:3]};

    // Sample counter is a down-counter; every action happens at terminal count 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        load    = 1'b0;
        frm_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_q && !rxs) begin
                    state_d = START;
                    cnt_d   = HALF_M1;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (!rxs) begin
                        state_d = DATA;
                        cnt_d   = FULL_M1;
                        bit_d   = 5'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    sh_d  = {sh_q[25:0], rxs};
                    cnt_d = FULL_M1;
                    if (bit_q == 5'd26) state_d = STOP;
                    else                bit_d   = bit_q + 5'd1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    load    = rxs;
                    frm_set = !rxs;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req         = CYC_I & STB_I;
        sel_data    = (ADR_I[ADDR_SIZE-1:0] == A_DATA);
        sel_status  = (ADR_I[ADDR_SIZE-1:0] == A_STATUS);
        sel_ctrl    = (ADR_I[ADDR_SIZE-1:0] == A_CTRL);
        mapped      = sel_data | sel_status | sel_ctrl;
        legal       = !(WE_I & sel_data);
        ACK_O       = req & mapped & legal;
        ERR_O       = req & !(mapped & legal);
        rd_data_ack = ACK_O & !WE_I & sel_data;
        st_wr       = ACK_O & WE_I & sel_status;
        ctrl_wr     = ACK_O & WE_I & sel_ctrl;
        DAT_O       = 32'd0;
        if (ACK_O && !WE_I) begin
            if (sel_data)        DAT_O = {5'd0, data_q};
            else if (sel_status) DAT_O = {28'd0, busy, frm_q, ovr_q, valid_q};
            else                 DAT_O = {31'd0, en_q};
        end
    end

    // A set event always beats a same-cycle clear.
    always_comb begin
        data_d  = load ? sh_q : data_q;
        valid_d = load ? 1'b1 : (rd_data_ack ? 1'b0 : valid_q);
        ovr_d   = (load & valid_q & !rd_data_ack) ? 1'b1 : ((st_wr & DAT_I[1]) ? 1'b0 : ovr_q);
        frm_d   = frm_set ? 1'b1 : ((st_wr & DAT_I[2]) ? 1'b0 : frm_q);
        en_d    = ctrl_wr ? DAT_I[0] : en_q;
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q <= IDLE;
            sync_q  <= '1;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            frm_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], data_i};
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            frm_q   <= frm_d;
            en_q    <= en_d;
        end
    end

`ifdef WB_DESERIALIZER_IRQ_EN
    logic irq_q;
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) irq_q <= 1'b0;
        else         irq_q <= valid_q | ovr_q | frm_q;
    end
    assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_wb_deserializer_out.sv
// Directed bench for wb_deserializer_out: serial frames in, Wishbone register checks out.
module tb_wb_deserializer_out;
    localparam int CPB = 4;

    logic        clk, rst_n, data_i, cyc, stb, we;
    logic [31:0] adr, dat_i, dat_o;
    logic        ack, err;
`ifdef WB_DESERIALIZER_IRQ_EN
    logic        irq;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] rd;
    logic        a, e;

    wb_deserializer_out #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2), .ADDR_SIZE(2)) dut (
        .CLK_I(clk), .RST_NI(rst_n), .data_i(data_i),
        .CYC_I(cyc), .STB_I(stb), .WE_I(we), .ADR_I(adr), .DAT_I(dat_i),
        .ACK_O(ack), .ERR_O(err), .DAT_O(dat_o)
`ifdef WB_DESERIALIZER_IRQ_EN
        , .irq_o(irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus tasks start and end on a falling edge; the request spans one rising edge.
    task automatic wb_rd(input logic [31:0] ad, output logic [31:0] d, output logic ak, output logic er);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = ad;
        #2;
        d = dat_o; ak = ack; er = err;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; adr = 32'd0;
    endtask

    task automatic wb_wr(input logic [31:0] ad, input logic [31:0] d, output logic ak, output logic er);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = ad; dat_i = d;
        #2;
        ak = ack; er = err;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'd0; dat_i = 32'd0;
    endtask

    // abort_at < 27 pulses reset when that payload bit would start.
    task automatic send_frame(input logic [26:0] f, input logic stop_bit, input int abort_at);
        data_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 26; i >= 0; i--) begin
            if (26 - i == abort_at) begin
                rst_n = 1'b0;
                data_i = 1'b1;
                @(negedge clk);
                rst_n = 1'b1;
                repeat (4) @(negedge clk);
                return;
            end
            data_i = f[i];
            repeat (CPB) @(negedge clk);
        end
        data_i = stop_bit;
        repeat (CPB) @(negedge clk);
        data_i = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; data_i = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = 32'd0; dat_i = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_ack", {31'd0, ack}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_dat", dat_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        wb_rd(32'd1, rd, a, e);
        chk("reset_status", rd, 32'h0);
        wb_rd(32'd2, rd, a, e);
        chk("reset_ctrl", rd, 32'h0);

        // Receiver disabled: a full frame must be ignored.
        send_frame(27'h1234567, 1'b1, 99);
        wb_rd(32'd1, rd, a, e);
        chk("disabled_status", rd, 32'h0);

        wb_wr(32'd2, 32'h1, a, e);
        chk("ctrl_wr_ack", {31'd0, a}, 32'd1);
        chk("ctrl_wr_err", {31'd0, e}, 32'd0);
        wb_rd(32'd2, rd, a, e);
        chk("ctrl_en", rd, 32'h1);

        // {9'h1BC,9'h012,9'h034}
        send_frame(27'h6F02434, 1'b1, 99);
        wb_rd(32'd1, rd, a, e);
        chk("f1_status", rd, 32'h1);
        wb_rd(32'd0, rd, a, e);
        chk("f1_data", rd, 32'h06F02434);
        chk("f1_data_ack", {31'd0, a}, 32'd1);
        wb_rd(32'd1, rd, a, e);
        chk("f1_status_after_read", rd, 32'h0);

        // Overrun: {9'h0FF,9'h100,9'h055} overwrites an unread frame.
        send_frame(27'h1234567, 1'b1, 99);
        send_frame(27'h3FE0055, 1'b1, 99);
        wb_rd(32'd1, rd, a, e);
        chk("ovr_status", rd, 32'h3);
        wb_wr(32'd1, 32'h2, a, e);
        wb_rd(32'd1, rd, a, e);
        chk("ovr_w1c_status", rd, 32'h1);
        wb_rd(32'd0, rd, a, e);
        chk("ovr_data", rd, 32'h03FE0055);
        wb_rd(32'd1, rd, a, e);
        chk("ovr_status_after_read", rd, 32'h0);

        // Framing error: bad stop bit drops the frame.
        send_frame(27'h0ABCDEF, 1'b0, 99);
        wb_rd(32'd1, rd, a, e);
        chk("frm_status", rd, 32'h4);
        wb_rd(32'd0, rd, a, e);
        chk("frm_data_kept", rd, 32'h03FE0055);
        wb_wr(32'd1, 32'h4, a, e);
        wb_rd(32'd1, rd, a, e);
        chk("frm_w1c_status", rd, 32'h0);

        // One-cycle low glitch on the idle line.
        data_i = 1'b0;
        @(negedge clk);
        data_i = 1'b1;
        repeat (20) @(negedge clk);
        wb_rd(32'd1, rd, a, e);
        chk("glitch_status", rd, 32'h0);

        // Bus errors.
        wb_rd(32'd3, rd, a, e);
        chk("rd_unmapped_err", {31'd0, e}, 32'd1);
        chk("rd_unmapped_ack", {31'd0, a}, 32'd0);
        chk("rd_unmapped_dat", rd, 32'd0);
        wb_wr(32'd0, 32'hFFFFFFFF, a, e);
        chk("wr_data_err", {31'd0, e}, 32'd1);
        chk("wr_data_ack", {31'd0, a}, 32'd0);
        wb_rd(32'd0, rd, a, e);
        chk("wr_data_no_effect", rd, 32'h03FE0055);

        // Reset mid-frame at bit 10, then a clean frame.
        send_frame(27'h5555555, 1'b1, 10);
        wb_rd(32'd1, rd, a, e);
        chk("rst_status", rd, 32'h0);
        wb_rd(32'd0, rd, a, e);
        chk("rst_data", rd, 32'h0);
        wb_rd(32'd2, rd, a, e);
        chk("rst_ctrl", rd, 32'h0);
        wb_wr(32'd2, 32'h1, a, e);
        send_frame(27'h4C3B2A1, 1'b1, 99);
        wb_rd(32'd1, rd, a, e);
        chk("post_rst_status", rd, 32'h1);
        wb_rd(32'd0, rd, a, e);
        chk("post_rst_data", rd, 32'h04C3B2A1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
